// File: rtl/fpu_seq.sv
// fpu_seq: streams element pairs from SRAM through an external FPU and writes the results back.
// For each element idx in 0..len-1 it reads A[adra+idx] and B[adrb+idx], issues them to the
// FPU with the opcode latched at start, waits for the result and writes it to Y[adry+idx].
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stt, abt                 start pulse (sampled in IDLE), abort (highest priority)
//   opc, adra/adrb/adry, len job parameters, latched at start
//   bsy, fin                 sequence active, one-cycle completion pulse
//   sram_ena/wea/addra/dina  SRAM write port
//   sram_enb/addrb/doutb     SRAM read port (data valid the cycle after enb)
//   fpu_opc/a/b/iv/ir        FPU issue handshake
//   fpu_ov/or/y              FPU result handshake
module fpu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        stt,
   input  logic        abt,
   input  logic [1:0]  opc,
   input  logic [13:0] adra,
   input  logic [13:0] adrb,
   input  logic [13:0] adry,
   input  logic [14:0] len,
   output logic        bsy,
   output logic        fin,
   output logic        sram_ena,
   output logic        sram_wea,
   output logic [13:0] sram_addra,
   output logic [63:0] sram_dina,
   output logic        sram_enb,
   output logic [13:0] sram_addrb,
   input  logic [63:0] sram_doutb,
   output logic [1:0]  fpu_opc,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_iv,
   input  logic        fpu_ir,
   input  logic        fpu_ov,
   output logic        fpu_or,
   input  logic [31:0] fpu_y
);

   typedef enum logic [2:0] {
      IDLE, RDA, RDB, CAP, ISS, WAIT, WR, DONE
   } state_t;

   state_t      state;
   logic [14:0] idx;
   logic [1:0]  opc_l;
   logic [13:0] adra_l;
   logic [13:0] adrb_l;
   logic [13:0] adry_l;
   logic [14:0] len_l;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] y_reg;
   logic        go;

   // Only the low word of each SRAM entry carries an operand.
   logic        doutb_hi_unused;
   assign doutb_hi_unused = ^sram_doutb[63:32];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         opc_l  <= '0;
         adra_l <= '0;
         adrb_l <= '0;
         adry_l <= '0;
         len_l  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         y_reg  <= '0;
      end else if (abt) begin
         // Abort drops everything, including a result already taken from the FPU.
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: if (stt) begin
               opc_l  <= opc;
               adra_l <= adra;
               adrb_l <= adrb;
               adry_l <= adry;
               len_l  <= len;
               idx    <= '0;
               state  <= (len == 15'd0) ? DONE : RDA;
            end
            RDA: state <= RDB;
            RDB: begin
               a_reg <= sram_doutb[31:0];  // read issued in RDA
               state <= CAP;
            end
            CAP: begin
               b_reg <= sram_doutb[31:0];  // read issued in RDB
               state <= ISS;
            end
            ISS: if (fpu_ir) state <= WAIT;
            WAIT: if (fpu_ov) begin
               y_reg <= fpu_y;
               state <= WR;
            end
            WR: begin
               if (idx == len_l - 15'd1) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 15'd1;
                  state <= RDA;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Enables and handshakes are decoded from the state register and masked by abt so that
   // nothing is read, written or handshaked in the cycle an abort is requested.
   assign go  = ~abt;
   assign bsy = (state != IDLE);

   always_comb begin
      fin        = 1'b0;
      sram_enb   = 1'b0;
      sram_addrb = '0;
      sram_ena   = 1'b0;
      sram_wea   = 1'b0;
      sram_addra = '0;
      sram_dina  = '0;
      fpu_iv     = 1'b0;
      fpu_a      = '0;
      fpu_b      = '0;
      fpu_opc    = '0;
      fpu_or     = 1'b0;
      unique case (state)
         RDA: begin
            sram_enb   = go;
            sram_addrb = adra_l + idx[13:0];  // 14-bit sum wraps naturally
         end
         RDB: begin
            sram_enb   = go;
            sram_addrb = adrb_l + idx[13:0];
         end
         ISS: begin
            fpu_iv  = go;
            fpu_a   = a_reg;
            fpu_b   = b_reg;
            fpu_opc = opc_l;
         end
         WAIT: fpu_or = go;
         WR: begin
            sram_ena   = go;
            sram_wea   = go;
            sram_addra = adry_l + idx[13:0];
            sram_dina  = {32'h0, y_reg};
         end
         DONE: fin = go;
         default: ;
      endcase
   end

endmodule
